fifo_ram_ctrl: RTL

//  Synchronous FIFO controller that drives the 128x8 simple dual-port RAM
//  (write port and read port) and presents push/pop FIFO semantics upstream.

---
 rtl/fifo_ram_ctrl_pkg.sv | 14 +
 rtl/fifo_ram_ctrl_if.sv | 40 ++++
 rtl/fifo_ram_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/fifo_ram_ctrl_pkg.sv
// rtl/fifo_ram_ctrl_pkg.sv - shared widths, depth, flag levels and pointer/count types
package fifo_ram_ctrl_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int AFULL_LVL  = 120;
  localparam int AEMPTY_LVL = 8;

  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// rtl/fifo_ram_ctrl_if.sv - push/pop handshake, RAM port and status bundle of the FIFO controller
interface fifo_ram_ctrl_if;
  import fifo_ram_ctrl_pkg::*;

  logic              flush_i;
  logic              push_i;
  data_t             push_data_i;
  logic              pop_i;

  logic              ram_wr_en_o;
  logic [ADDR_W-1:0] ram_wr_addr_o;
  data_t             ram_wr_data_o;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_rd_addr_o;

  logic              rd_valid_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  cnt_t              count_o;
  logic              overflow_o;
  logic              underflow_o;

  // master: producer/consumer side; slave: the controller
  modport master (
    output flush_i, push_i, push_data_i, pop_i,
    input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o,
    input  rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
    input  count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, push_data_i, pop_i,
    output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, ram_rd_en_o, ram_rd_addr_o,
    output rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
    output count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - FIFO pointer/count/flag controller for a 1-cycle-latency simple dual-port RAM
module fifo_ram_ctrl
  import fifo_ram_ctrl_pkg::*;
#(
  parameter int AFULL_THR  = AFULL_LVL,
  parameter int AEMPTY_THR = AEMPTY_LVL
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fifo_ram_ctrl_if.slave bus
);

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_THR);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THR);

  ptr_t wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
  cnt_t count_q, count_n;
  logic full_q, empty_q, afull_q, aempty_q;
  logic ovf_q, unf_q, ovf_n, unf_n;
  logic rd_valid_q;
  logic pop_ok, push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it
  always_comb begin
    pop_ok  = bus.pop_i & ~empty_q & ~bus.flush_i;
    push_ok = bus.push_i & (~full_q | pop_ok) & ~bus.flush_i;
  end

  always_comb begin
    wr_ptr_n = wr_ptr_q + ptr_t'(push_ok);
    rd_ptr_n = rd_ptr_q + ptr_t'(pop_ok);
    count_n  = count_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
    ovf_n    = ovf_q | (bus.push_i & ~push_ok);
    unf_n    = unf_q | (bus.pop_i & empty_q);
    if (bus.flush_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
      ovf_n    = 1'b0;
      unf_n    = 1'b0;
    end
  end

  // Flags come from count_n so they line up with the registered count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_n;
      rd_ptr_q   <= rd_ptr_n;
      count_q    <= count_n;
      full_q     <= (count_n == DEPTH_C);
      empty_q    <= (count_n == '0);
      afull_q    <= (count_n >= AFULL_C);
      aempty_q   <= (count_n <= AEMPTY_C);
      ovf_q      <= ovf_n;
      unf_q      <= unf_n;
      rd_valid_q <= pop_ok;
    end
  end

  assign bus.ram_wr_en_o    = push_ok;
  assign bus.ram_wr_addr_o  = wr_ptr_q[ADDR_W-1:0];
  assign bus.ram_wr_data_o  = bus.push_data_i;
  assign bus.ram_rd_en_o    = pop_ok;
  assign bus.ram_rd_addr_o  = rd_ptr_q[ADDR_W-1:0];
  assign bus.rd_valid_o     = rd_valid_q;
  assign bus.full_o         = full_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_full_o  = afull_q;
  assign bus.almost_empty_o = aempty_q;
  assign bus.count_o        = count_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;

endmodule
